// File: rtl/sbox_masking_pkg.sv
// sbox_masking_pkg: shared constants, FSM states and share helper for the
// HPC2 d=3 Skinny S-box sequencer.
package sbox_masking_pkg;
   localparam int ORDER = 3;
   localparam int NB = 4;
   localparam int SW = NB*(ORDER+1);
   localparam int RND_W = 24;
   localparam int LATENCY = 5;
   localparam int TIMEOUT = LATENCY+3;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   localparam logic [31:0] SEED = 32'hACE12468;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
   function automatic logic [NB-1:0] share(input logic [SW-1:0] v, input int s);
      return v[NB*s +: NB];
   endfunction
endpackage

// File: rtl/sbox_fresh_lfsr.sv
// sbox_fresh_lfsr: 32-bit Galois LFSR supplying fresh randomness, with seed
// load; a zero seed falls back to SEED so the register never locks up.
module sbox_fresh_lfsr
   import sbox_masking_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      seed_i,
   input  logic             seed_load_i,
   output logic [RND_W-1:0] fresh
);
   logic [31:0] st;
   always_ff @(posedge clk or posedge rst)
      if (rst) st <= SEED;
      else st <= seed_load_i ? ((seed_i == 32'h0) ? SEED : seed_i)
                             : ({1'b0, st[31:1]} ^ ({32{st[0]}} & LFSR_TAPS));
   assign fresh = st[RND_W-1:0];
endmodule

// File: rtl/sbox_hpc2_d3_sequencer.sv
// sbox_hpc2_d3_sequencer: handshakes one masked nibble at a time into the
// clock-gated HPC2 S-box core, restarts it, and returns its output shares.
module sbox_hpc2_d3_sequencer
   import sbox_masking_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      seed_i,
   input  logic             seed_load_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SW-1:0]    in_shares,
   output logic             core_rst,
   output logic [SW-1:0]    core_x,
   output logic [RND_W-1:0] core_fresh,
   input  logic [SW-1:0]    core_y,
   input  logic             core_synch,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SW-1:0]    out_shares,
   output logic             err
);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [RND_W-1:0] prng;
   logic accept, capture, expire, release_x;

   sbox_fresh_lfsr u_lfsr (
      .clk         (clk),
      .rst         (rst),
      .seed_i      (seed_i),
      .seed_load_i (seed_load_i),
      .fresh       (prng)
   );

   assign in_ready  = (state == IDLE) && !rst;
   assign accept    = (state == IDLE) && in_valid;
   assign capture   = (state == WAIT) && core_synch;
   assign expire    = (state == WAIT) && !core_synch && (cnt == CW'(TIMEOUT-1));
   assign release_x = (state == HOLD) && out_ready;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? LAUNCH : IDLE;
         LAUNCH:  state_n = WAIT;
         WAIT:    state_n = capture ? HOLD : (expire ? IDLE : WAIT);
         HOLD:    state_n = release_x ? IDLE : HOLD;
         default: state_n = IDLE;
      endcase
   end

   // Shares and fresh bits only move on accept or release, so the core sees
   // constant operands for its whole evaluation.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         core_rst   <= 1'b1;
         core_x     <= '0;
         core_fresh <= '0;
         out_shares <= '0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
         cnt        <= '0;
      end else begin
         core_rst  <= (state_n == LAUNCH);
         out_valid <= (state_n == HOLD);
         err       <= err | expire;
         cnt       <= (state == WAIT) ? cnt + 1'b1 : '0;
         if (accept) begin
            core_x     <= in_shares;
            core_fresh <= prng;
         end else if (release_x) begin
            core_x     <= '0;
            core_fresh <= '0;
         end
         if (capture) out_shares <= core_y;
      end
endmodule
